// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared types for the pattern serializer
package ser_pkg;

  typedef enum logic {IDLE, SHIFT} ser_state_t;

endpackage

// File: rtl/ser_hold_buf.sv
// rtl/ser_hold_buf.sv - one-entry hold register that parks a word while the current frame drains
module ser_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_word,
  input  logic             take,
  output logic [WIDTH-1:0] word,
  output logic             full
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      full <= 1'b0;
    end else begin
      if (load) begin
        word <= load_word;
      end
      full <= load | (full & ~take);
    end
  end

endmodule

// File: rtl/pattern_serializer.sv
// rtl/pattern_serializer.sv - parallel-to-serial feeder for the run-pattern detector
module pattern_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  ser_state_t       state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n, hold_word;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic             hold_full, accept, last_bit, direct_load, hold_load, hold_take;

  assign load_ready  = !hold_full;
  assign accept      = load_valid && load_ready;
  assign last_bit    = (state == SHIFT) && shift_en && (bit_cnt == LAST_BIT);
  // A word goes straight to the shifter only when nothing is queued ahead of it
  assign direct_load = accept && ((state == IDLE) || (last_bit && !hold_full));
  assign hold_load   = accept && !direct_load;
  assign hold_take   = hold_full && ((state == IDLE) || last_bit);

  ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (hold_load),
    .load_word(load_data),
    .take     (hold_take),
    .word     (hold_word),
    .full     (hold_full)
  );

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    if (state == IDLE) begin
      if (hold_take) begin
        state_n   = SHIFT;
        shreg_n   = hold_word;
        bit_cnt_n = '0;
      end else if (direct_load) begin
        state_n   = SHIFT;
        shreg_n   = load_data;
        bit_cnt_n = '0;
      end
    end else if (shift_en) begin
      if (last_bit) begin
        bit_cnt_n = '0;
        if (hold_full) begin
          shreg_n = hold_word;
        end else if (direct_load) begin
          shreg_n = load_data;
        end else begin
          state_n = IDLE;
        end
      end else begin
        shreg_n   = LSB_FIRST ? (shreg >> 1) : (shreg << 1);
        bit_cnt_n = bit_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      frame_done <= last_bit;
      if (last_bit) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

  assign ser_valid = (state == SHIFT);
  assign ser_out   = (state == SHIFT) ? (LSB_FIRST ? shreg[0] : shreg[WIDTH-1]) : IDLE_BIT;

endmodule

// File: tb/tb_pattern_serializer.sv
// tb/tb_pattern_serializer.sv - directed and randomized checks of pattern_serializer
module tb_pattern_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  load_data;
  logic        load_valid, load_ready, shift_en, ser_out, ser_valid, frame_done;
  logic [15:0] frame_cnt;
  logic [7:0]  m_load_data;
  logic        m_load_valid, m_load_ready, m_shift_en, m_ser_out, m_ser_valid, m_frame_done;
  logic [1:0]  m_frame_cnt;

  int tests = 0;
  int fails = 0;

  logic exp_q[$];
  int   frames;
  int   consumed;
  bit   done_pending;

  always #5 clk = ~clk;

  pattern_serializer dut (
    .clk(clk), .rst_n(rst_n), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .shift_en(shift_en), .ser_out(ser_out), .ser_valid(ser_valid),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  pattern_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_BIT(1'b0), .CNT_W(2)) dut_m (
    .clk(clk), .rst_n(rst_n), .load_data(m_load_data), .load_valid(m_load_valid),
    .load_ready(m_load_ready), .shift_en(m_shift_en), .ser_out(m_ser_out), .ser_valid(m_ser_valid),
    .frame_done(m_frame_done), .frame_cnt(m_frame_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] w, w2;
    int df1, df2;
    int cnt_exp[4] = '{1, 2, 3, 0};

    rst_n = 1'b0; load_data = '0; load_valid = 1'b0; shift_en = 1'b0;
    m_load_data = '0; m_load_valid = 1'b0; m_shift_en = 1'b0;
    repeat (3) tick();
    check("rst_ser_out", ser_out, 0);
    check("rst_ser_valid", ser_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    #1;
    check("rst_load_ready", load_ready, 1);

    // single word, LSB first
    w = 8'hF0; load_data = w; load_valid = 1'b1; shift_en = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t2_valid", ser_valid, 1);
      check("t2_bit", ser_out, w[i]);
      tick();
    end
    check("t2_done", frame_done, 1);
    check("t2_cnt", frame_cnt, 1);
    check("t2_idle_valid", ser_valid, 0);
    check("t2_idle_bit", ser_out, 0);
    tick();
    check("t2_done_clear", frame_done, 0);

    // back-to-back frames through the hold buffer
    w = 8'hFF; w2 = 8'h00; load_data = w; load_valid = 1'b1;
    tick();
    load_data = w2;
    df1 = 0; df2 = 0;
    for (int c = 1; c <= 17; c++) begin
      if (c == 2) begin
        check("t3_hold_ready", load_ready, 0);
        load_valid = 1'b0;
      end
      if (frame_done) begin
        if (df1 == 0) df1 = c;
        else df2 = c;
      end
      if (c <= 16) begin
        check("t3_valid", ser_valid, 1);
        if (c <= 8) check("t3_bit_a", ser_out, w[c-1]);
        else        check("t3_bit_b", ser_out, w2[c-9]);
        tick();
      end
    end
    check("t3_done1", df1, 9);
    check("t3_done2", df2, 17);
    check("t3_cnt", frame_cnt, 3);
    check("t3_end_valid", ser_valid, 0);
    tick();

    // stall with shift_en low while bit 3 is on the line
    w = 8'hA5; load_data = w; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t4_bit", ser_out, w[i]);
      if (i == 3) begin
        shift_en = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          check("t4_frozen", ser_out, w[3]);
          check("t4_frozen_valid", ser_valid, 1);
        end
        shift_en = 1'b1;
      end
      tick();
    end
    check("t4_done", frame_done, 1);
    check("t4_cnt", frame_cnt, 4);
    tick();

    // randomized traffic against a bit-stream scoreboard
    frames = 4; consumed = 0; done_pending = 1'b0; exp_q.delete();
    for (int n = 0; n < 440; n++) begin
      check("rnd_done", frame_done, done_pending);
      check("rnd_valid", ser_valid, exp_q.size() != 0);
      check("rnd_ready", load_ready, exp_q.size() <= 8);
      check("rnd_cnt", frame_cnt, 16'(frames));
      if (n >= 400) begin
        load_valid = 1'b0;
        shift_en   = 1'b1;
      end else begin
        shift_en = ($urandom_range(0, 3) != 0);
        if (!load_valid || load_ready) begin
          load_valid = 1'($urandom_range(0, 1));
          load_data  = 8'($urandom);
        end
      end
      done_pending = 1'b0;
      if (ser_valid && shift_en && exp_q.size() != 0) begin
        check("rnd_bit", ser_out, exp_q.pop_front());
        consumed++;
        if (consumed % 8 == 0) begin
          frames++;
          done_pending = 1'b1;
        end
      end
      if (load_valid && load_ready) begin
        for (int i = 0; i < 8; i++) exp_q.push_back(load_data[i]);
      end
      tick();
    end
    check("rnd_drained", exp_q.size(), 0);
    check("rnd_final_cnt", frame_cnt, 16'(frames));

    // reset mid-frame with a word held
    w = 8'($urandom); w2 = 8'($urandom);
    load_data = w; load_valid = 1'b1; shift_en = 1'b1;
    tick();
    load_data = w2;
    tick();
    load_valid = 1'b0;
    check("t5_held", load_ready, 0);
    repeat (3) tick();
    check("t5_bit4", ser_out, w[4]);
    #2 rst_n = 1'b0;
    #1;
    check("t5_ser_out", ser_out, 0);
    check("t5_ser_valid", ser_valid, 0);
    check("t5_frame_done", frame_done, 0);
    check("t5_frame_cnt", frame_cnt, 0);
    check("t5_ready", load_ready, 1);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t5_no_done", frame_done, 0);
      check("t5_no_valid", ser_valid, 0);
    end
    w = 8'($urandom); load_data = w; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t5_new_bit", ser_out, w[i]);
      tick();
    end
    check("t5_new_done", frame_done, 1);
    check("t5_new_cnt", frame_cnt, 1);

    // MSB-first instance with a 2-bit wrapping frame counter
    m_shift_en = 1'b1;
    for (int f = 0; f < 4; f++) begin
      w = (f == 0) ? 8'h81 : 8'($urandom);
      m_load_data = w; m_load_valid = 1'b1;
      tick();
      m_load_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
        check("t6_valid", m_ser_valid, 1);
        check("t6_bit", m_ser_out, w[7-i]);
        tick();
      end
      check("t6_done", m_frame_done, 1);
      check("t6_cnt", m_frame_cnt, cnt_exp[f]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
